// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT path: frame-controller state encoding,
// default frame geometry and the index-width helper.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_STREAM,
        ST_DONE
    } fft_state_e;

    localparam int unsigned NFFT_DEFAULT      = 512;
    localparam int unsigned MUX_START_DEFAULT = 250;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FFT core sink port: waits for sink_ready, streams
// NFFT slots with sop/eop framing, drives the buffer index and filter select.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned NFFT      = NFFT_DEFAULT,
    parameter int unsigned MUX_START = MUX_START_DEFAULT,
    parameter int unsigned FCNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     sink_ready,
    output logic                     sink_valid,
    output logic                     sink_sop,
    output logic                     sink_eop,
    output logic [clog2(NFFT)-1:0]   smp_idx,
    output logic                     filtmx,
    output logic                     busy,
    output logic                     done,
    output logic [FCNT_W-1:0]        frame_cnt
);

    localparam int unsigned IW = clog2(NFFT);
    localparam logic [IW-1:0] IDX_LAST = IW'(NFFT - 1);
    localparam logic [IW-1:0] IDX_MUX  = IW'(MUX_START - 1);

    fft_state_e          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                filtmx_q, filtmx_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            filtmx_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            filtmx_q <= filtmx_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        filtmx_d = filtmx_q;
        fcnt_d   = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_WAIT_RDY;
                    idx_d    = '0;
                    filtmx_d = 1'b0;
                end
            end
            ST_WAIT_RDY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sink_ready) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // abort suppresses the transfer entirely, so index and filtmx freeze
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sink_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        fcnt_d  = fcnt_q + FCNT_W'(1);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                    if (idx_q == IDX_MUX) begin
                        filtmx_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d  = ST_WAIT_RDY;
                    idx_d    = '0;
                    filtmx_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sink_valid = (state_q == ST_STREAM);
    assign sink_sop   = sink_valid && (idx_q == '0);
    assign sink_eop   = sink_valid && (idx_q == IDX_LAST);
    assign smp_idx    = idx_q;
    assign filtmx     = filtmx_q;
    assign busy       = (state_q == ST_WAIT_RDY) || (state_q == ST_STREAM);
    assign done       = (state_q == ST_DONE);
    assign frame_cnt  = fcnt_q;

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Sequences one NFFT-point frame into the FFT core's sink port. On a start request it waits for the core to raise sink_ready, then streams NFFT sample slots with valid/sop/eop framing, honouring backpressure. It also drives the sample-buffer read index and the filter mux select filtmx. It sits between the sample buffer and the FFT core and is the single owner of the core's sink handshake.

## Interface
- NFFT, 512: samples per frame; power of two, 8..4096.
- MUX_START, 250: sample index at which filtmx switches to 1; 1..NFFT-1.
- FCNT_W, 16: width of the frame counter.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  frame request pulse; sampled in IDLE and DONE only.
- abort  in  1  cancels the current frame; wins over start.
- sink_ready  in  1  FFT core ready.
- sink_valid  out  1  sample slot valid.
- sink_sop  out  1  first sample of frame, qualified by sink_valid.
- sink_eop  out  1  last sample of frame, qualified by sink_valid.
- smp_idx  out  log2(NFFT)  sample-buffer read index for the current slot.
- filtmx  out  1  filter mux select: 0 for early samples, 1 from MUX_START on.
- busy  out  1  high in WAIT_RDY and STREAM.
- done  out  1  one-cycle pulse after a completed frame.
- frame_cnt  out  FCNT_W  completed-frame count; wraps modulo 2^FCNT_W.

## Operation
- States: IDLE, WAIT_RDY, STREAM, DONE. Reset enters IDLE.
- IDLE: on start with abort low, go to WAIT_RDY and clear smp_idx and filtmx.
- WAIT_RDY: sink_valid is 0. When sink_ready=1, go to STREAM.
- STREAM:
  - sink_valid=1 throughout.
  - A transfer is a cycle with sink_valid=1 and sink_ready=1.
  - smp_idx increments after each transfer and holds while sink_ready=0.
  - The transfer with smp_idx=NFFT-1 goes to DONE.
- DONE: lasts exactly one cycle.
  - done=1 and frame_cnt has already incremented on the entering edge.
  - start in DONE behaves as in IDLE: back-to-back frames go to WAIT_RDY.
  - Otherwise go to IDLE.
- sink_sop = sink_valid & (smp_idx==0); sink_eop = sink_valid & (smp_idx==NFFT-1). Both are decoded from flops only.
- filtmx:
  - Set on the edge of the transfer with smp_idx=MUX_START-1.
  - Holds through DONE and IDLE; cleared only on start acceptance or reset.
- abort in WAIT_RDY, STREAM or DONE:
  - Go to IDLE next edge; sink_valid low from that edge.
  - No done pulse; frame_cnt unchanged; filtmx retains its value.
- start while busy is ignored, with no queueing.
- smp_idx holds after the last transfer. Its width is log2(NFFT), so no wrap occurs inside a frame.

## Timing
- Reset values: sink_valid, sink_sop, sink_eop, filtmx, busy, done = 0; smp_idx = 0; frame_cnt = 0.
- All outputs change only on clk edges; no combinational input-to-output paths.
- With start at edge k and sink_ready high:
  - WAIT_RDY during cycle k+1; first valid (sop) at cycle k+2.
  - eop at cycle k+NFFT+1; done at cycle k+NFFT+2.
- sink_ready low during STREAM stalls the frame one cycle per low cycle. sink_valid and smp_idx hold, so sop and eop persist until their transfers.
- filtmx is 1 in the same cycle that smp_idx=MUX_START is presented.

## Structure
- Shared package fft_ctrl_pkg holds:
  - state enum type;
  - default NFFT and MUX_START constants;
  - index-width function clog2(NFFT).
- Other FFT-path blocks import this package.
- Single module: an FSM plus index counter, filtmx flop and frame counter. No sub-module is warranted.

## Test plan
- Reset mid-STREAM at smp_idx=100 -> all outputs at reset values immediately, state IDLE, frame_cnt=0.
- start pulse with sink_ready=1 constantly, NFFT=512 -> 512 consecutive valid cycles, sop on idx 0, eop on idx 511, filtmx 0 for idx 0..249 and 1 from idx 250, done one cycle after eop, frame_cnt=1.
- sink_ready low 3 cycles at idx 10 and 5 cycles at idx 511 -> idx holds at 10, then 511 with eop held, frame completes in 520 valid cycles, single done.
- start asserted in the DONE cycle -> WAIT_RDY next edge, filtmx cleared, second frame with sop; frame_cnt ends at 2 after two frames.
- abort at idx 300, and separately start+abort together in IDLE -> IDLE next edge, valid low, no done, frame_cnt unchanged, filtmx stays 1 in the first case and 0 in the second.
- frame_cnt preloaded via 65536 short frames (NFFT=8) -> wraps to 0; start during STREAM ignored, no extra sop.
